fifo_wr_arb: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 37 +++
 rtl/fifo_wr_arb_rr_pick.sv | 22 ++
 rtl/fifo_wr_arb.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and other
// round-robin schedulers.
package fifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Width of every statistics counter.
    localparam int STAT_W = 32;

    // Widest request vector the rotate search supports, and its index width.
    localparam int RR_MAX = 16;
    localparam int RR_IW  = 4;

    // Next index at or after (last+1) mod n whose req bit is set, wrapping.
    // Returns last when no bit is set; callers qualify with |req.
    function automatic logic [RR_IW-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                 input logic [RR_IW-1:0]  last,
                                                 input int                n);
        logic [RR_IW-1:0] idx;
        logic             hit;
        int               j;
        idx = last;
        hit = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            j = (int'(last) + k) % n;
            if (k <= n && !hit && req[j[RR_IW-1:0]]) begin
                idx = j[RR_IW-1:0];
                hit = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational rotate-priority encoder. Finds the first set
// request bit searching upward from last_i+1, wrapping at N.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);

    localparam int IW = $clog2(N);

    // Rotate search over the request vector.
    always_comb begin
        idx_o   = IW'(rr_next(RR_MAX'(req_i), RR_IW'(last_i), N));
        found_o = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port between
// NUM_REQ requesters, granting whole bursts of up to MAX_BURST beats.
// Optional per-requester beat and stall counters: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  stat_beats,
    output logic [STAT_W-1:0]          stat_stall
`endif
);

    localparam int                IW       = $clog2(NUM_REQ);
    localparam int                CW       = 9;  // holds MAX_BURST up to 256
    localparam logic [CW-1:0]     MAX_CNT  = CW'(MAX_BURST);
    localparam logic [IW-1:0]     LAST_RST = IW'(NUM_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          sel_valid;
    logic          sel_last;
    logic          beat;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Arbitration FSM next state plus the write-port mux and handshakes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        sel_valid    = req_valid[grant_q];
        sel_last     = req_last[grant_q];
        fifo_data_in = req_data[int'(grant_q)*WIDTH +: WIDTH];

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d      = ARB_BURST;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            ARB_BURST: begin
                req_ready[grant_q] = ~fifo_full;
                fifo_wr_en         = sel_valid & ~fifo_full;
                if (fifo_wr_en) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_last || beat_cnt_d == MAX_CNT) begin
                        state_d = ARB_IDLE;
                    end
                end else if (!sel_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        beat = fifo_wr_en;
    end

    // State, grant and beat-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from the values before the edge.
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == ARB_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [NUM_REQ];
    logic [STAT_W-1:0] stall_q;

    // Wrapping per-requester beat counters and the stall counter.
    always_ff @(posedge clk) begin
        // NOTE: this small counter array is cleared on reset because software
        // reads it as zero after reset; it is flops, not a RAM.
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (beat) begin
                beats_q[grant_q] <= beats_q[grant_q] + 1'b1;
            end
            if (busy && sel_valid && fifo_full) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_beats[gi*STAT_W +: STAT_W] = beats_q[gi];
    end
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus a randomized
// phase, all compared against a transaction-rule reference model.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic [1:0]     grant_idx;
    logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*32-1:0] stat_beats;
    logic [31:0]     stat_stall;
`endif

    fifo_wr_arb #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_idx    (grant_idx),
        .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester sources: each sends beats {src, seq}, last every src_len beats.
    bit src_en    [N];
    int src_total [N];
    int src_len   [N];
    int src_seq   [N];
    bit rnd_mode;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];
    int  cyc = 0;

    // Reference model: burst-level rules of the arbiter.
    bit          m_busy;
    int          m_g;
    int          m_last;
    int          m_cnt;
    int unsigned m_beats [N];
    int unsigned m_stall;

    function automatic logic [31:0] beat_word(input int src, input int seq);
        return {8'(src), 24'(seq)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src_en[i] && (src_seq[i] < src_total[i]) &&
                           (!rnd_mode || ($urandom_range(0, 9) < 8));
            req_last[i]  = (src_len[i] != 0) && ((src_seq[i] % src_len[i]) == src_len[i] - 1);
            req_data[i*W +: W] = beat_word(i, src_seq[i]);
        end
        if (rnd_mode) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_last = N - 1;
        m_cnt  = 0;
        for (int i = 0; i < N; i++) m_beats[i] = 0;
        m_stall = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance model and sources.
    task automatic tick();
        logic [N-1:0] e_ready;
        logic [N-1:0] acc;
        logic         e_wr;
        logic [W-1:0] e_data;
        @(negedge clk);
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = req_data[m_g*W +: W];
        if (m_busy) begin
            e_ready[m_g] = ~fifo_full;
            e_wr         = req_valid[m_g] & ~fifo_full;
        end
        check("busy",      64'(busy),         64'(m_busy));
        check("grant_idx", 64'(grant_idx),    64'(m_g));
        check("wr_en",     64'(fifo_wr_en),   64'(e_wr));
        check("ready",     64'(req_ready),    64'(e_ready));
        check("data_in",   64'(fifo_data_in), 64'(e_data));
        acc = req_valid & req_ready;
        if (fifo_wr_en) wlog.push_back('{cyc, fifo_data_in});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (!m_busy && req_valid[j]) begin
                    m_busy = 1'b1;
                    m_g    = j;
                    m_last = j;
                    m_cnt  = 0;
                end
            end
        end else begin
            if (e_wr) m_beats[m_g]++;
            if (req_valid[m_g] && fifo_full) m_stall++;
            if (e_wr) begin
                m_cnt++;
                if (req_last[m_g] || m_cnt == MB) m_busy = 1'b0;
            end else if (!req_valid[m_g]) begin
                m_busy = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) if (acc[i]) src_seq[i]++;
        cyc++;
        #1;
        drive();
    endtask

    task automatic run_until(input int nlog, input int maxc);
        for (int c = 0; c < maxc && wlog.size() < nlog; c++) tick();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rnd_mode  = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b0; src_total[i] = 0; src_len[i] = 0; src_seq[i] = 0;
        end
        drive();
        tick();
        tick();
        check("rst_busy",  64'(busy),       64'(0));
        check("rst_grant", 64'(grant_idx),  64'(0));
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_ready", 64'(req_ready),  64'(0));
        rst = 1'b0;
        drive();
        wlog.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int stall_n;
        rst       = 1'b1;
        rnd_mode  = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b0; src_total[i] = 0; src_len[i] = 0; src_seq[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Scenario 1: requesters 0 and 2, three-beat packets.
        do_reset();
        src_en[0] = 1'b1; src_total[0] = 3; src_len[0] = 3;
        src_en[2] = 1'b1; src_total[2] = 3; src_len[2] = 3;
        drive();
        c0 = cyc;
        run_until(6, 40);
        repeat (3) tick();
        check("s1_count", 64'(wlog.size()), 64'(6));
        for (int k = 0; k < wlog.size() && k < 6; k++)
            check("s1_data", 64'(wlog[k].data), 64'(beat_word(k < 3 ? 0 : 2, k % 3)));
        if (wlog.size() >= 6) begin
            check("s1_latency", 64'(wlog[0].cyc - c0),          64'(1));
            check("s1_back2b",  64'(wlog[2].cyc - wlog[0].cyc), 64'(2));
            check("s1_bubble",  64'(wlog[3].cyc - wlog[2].cyc), 64'(2));
        end
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("s1_stat_beats", 64'(stat_beats[i*32 +: 32]), 64'((i % 2 == 0) ? 3 : 0));
        check("s1_stat_stall", 64'(stat_stall), 64'(0));
`endif

        // Scenario 2: all requesters continuously valid, never last.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b1; src_total[i] = 1000; src_len[i] = 0;
        end
        drive();
        run_until(40, 120);
        check("s2_count", 64'(wlog.size()), 64'(40));
        for (int k = 0; k < wlog.size() && k < 40; k++) begin
            check("s2_data", 64'(wlog[k].data), 64'(beat_word((k / MB) % N, (k / (MB * N)) * MB + k % MB)));
            check("s2_cycle", 64'(wlog[k].cyc - wlog[0].cyc), 64'(k + k / MB));
        end

        // Scenario 3: fifo_full for 5 cycles after beat 4 of a burst.
        do_reset();
        src_en[0] = 1'b1; src_total[0] = 20; src_len[0] = 0;
        drive();
        stall_n = 0;
        for (int c = 0; c < 60 && wlog.size() < 9; c++) begin
            fifo_full = (wlog.size() == 4) && (stall_n < 5);
            if (fifo_full) stall_n++;
            tick();
        end
        check("s3_count", 64'(wlog.size()), 64'(9));
        for (int k = 0; k < wlog.size() && k < 9; k++)
            check("s3_data", 64'(wlog[k].data), 64'(beat_word(0, k)));
        if (wlog.size() >= 9) begin
            check("s3_stall_gap", 64'(wlog[4].cyc - wlog[3].cyc), 64'(6));
            check("s3_burst_end", 64'(wlog[8].cyc - wlog[7].cyc), 64'(2));
        end
`ifdef FIFO_WR_ARB_STATS_EN
        check("s3_stat_stall", 64'(stat_stall), 64'(5));
`endif

        // Scenario 4: granted requester drops valid after 2 beats.
        do_reset();
        src_en[1] = 1'b1; src_total[1] = 2; src_len[1] = 0;
        src_en[2] = 1'b1; src_total[2] = 3; src_len[2] = 3;
        drive();
        run_until(5, 40);
        check("s4_count", 64'(wlog.size()), 64'(5));
        for (int k = 0; k < wlog.size() && k < 5; k++)
            check("s4_data", 64'(wlog[k].data), 64'(k < 2 ? beat_word(1, k) : beat_word(2, k - 2)));
        if (wlog.size() >= 3)
            check("s4_regrant", 64'(wlog[2].cyc - wlog[1].cyc), 64'(3));

        // Scenario 5: reset during beat 3 of a requester 1 burst.
        do_reset();
        src_en[1] = 1'b1; src_total[1] = 100; src_len[1] = 0;
        drive();
        run_until(2, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_beats",  64'(wlog.size()), 64'(3));
        check("s5_busy",   64'(busy),        64'(0));
        check("s5_grant",  64'(grant_idx),   64'(0));
        check("s5_wr_en",  64'(fifo_wr_en),  64'(0));
        check("s5_ready",  64'(req_ready),   64'(0));
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b1; src_total[i] = 100;
        end
        drive();
        tick();
        check("s5_next_busy",  64'(busy),      64'(1));
        check("s5_next_grant", 64'(grant_idx), 64'(0));

        // Randomized phase: random valid gaps, packet lengths, full and reset.
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b1; src_total[i] = 1 << 30; src_len[i] = $urandom_range(0, 6);
        end
        drive();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("rnd_stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_beats[i]));
        check("rnd_stat_stall", 64'(stat_stall), 64'(m_stall));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
